// File: rtl/posit_mult_result_buf.sv
// Result FIFO behind the posit multiplier: canonicalises each result, presents it FWFT over valid/ready.
// Define POSIT_RES_STATS_EN to add the saturating NaR/zero result counters (inf_cnt, zero_cnt).
module posit_mult_result_buf #(
   parameter  int N     = 16,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   input  logic          in_inf,
   input  logic          in_zero,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          out_inf,
   output logic          out_zero,
   output logic [AW:0]   count,
   input  logic          clr,
`ifdef POSIT_RES_STATS_EN
   output logic [15:0]   inf_cnt,
   output logic [15:0]   zero_cnt,
`endif
   output logic          ovf_sticky
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [N+1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          full, wr_en, rd_en, drop;
   logic [N+1:0]  wr_entry;
   logic [N+1:0]  head;

   assign full      = (count_q == DEPTH_C);
   assign in_ready  = ~full;
   assign out_valid = (count_q != '0);
   assign wr_en     = in_valid & ~full;
   assign rd_en     = out_valid & out_ready;
   assign drop      = in_valid & full;

   // Entry layout is {inf, zero, data}; NaR wins over zero.
   always_comb begin
      wr_entry = {2'b00, in_data};
      if (in_inf) begin
         wr_entry = {2'b10, 1'b1, {(N-1){1'b0}}};
      end else if (in_zero) begin
         wr_entry = {2'b01, {N{1'b0}}};
      end
   end

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (clr) begin
         ovf_d = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // First-word-fall-through head, forced to zero while empty.
   assign head       = mem_q[rd_ptr_q];
   assign out_data   = out_valid ? head[N-1:0] : '0;
   assign out_zero   = out_valid & head[N];
   assign out_inf    = out_valid & head[N+1];
   assign count      = count_q;
   assign ovf_sticky = ovf_q;

`ifdef POSIT_RES_STATS_EN
   logic [15:0] inf_cnt_q, inf_cnt_d;
   logic [15:0] zero_cnt_q, zero_cnt_d;

   always_comb begin
      inf_cnt_d  = inf_cnt_q;
      zero_cnt_d = zero_cnt_q;
      if (clr) begin
         inf_cnt_d  = '0;
         zero_cnt_d = '0;
      end else if (wr_en) begin
         if (in_inf && inf_cnt_q != 16'hFFFF) begin
            inf_cnt_d = inf_cnt_q + 16'd1;
         end
         if (in_zero && !in_inf && zero_cnt_q != 16'hFFFF) begin
            zero_cnt_d = zero_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inf_cnt_q  <= '0;
         zero_cnt_q <= '0;
      end else begin
         inf_cnt_q  <= inf_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign inf_cnt  = inf_cnt_q;
   assign zero_cnt = zero_cnt_q;
`endif

endmodule
